// File: rtl/ibex_pkg.sv
// Shared types and constants for the register-file write-back queue.
// The entry type fixes the stored data format at the RV32 register width.
package ibex_pkg;

    localparam int unsigned RfWbDepthDefault = 4;
    localparam int unsigned RfWbDataWidth    = 32;

    typedef struct packed {
        logic [4:0]               waddr;
        logic [RfWbDataWidth-1:0] wdata;
    } rf_wb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_fwd_lookup.sv
// Youngest-match search over the pending write-back entries for one read port.
// Entries are walked from oldest (rptr_i) to youngest, so the last match wins.
module ibex_rf_wb_fwd_lookup import ibex_pkg::*; #(
    parameter int unsigned DataWidth = RfWbDataWidth,
    parameter int unsigned Depth     = RfWbDepthDefault,
    localparam int unsigned PtrW     = $clog2(Depth)
) (
    input  rf_wb_entry_t         entries_i [Depth],
    input  logic [PtrW-1:0]      rptr_i,
    input  logic [PtrW:0]        count_i,
    input  logic [4:0]           raddr_i,
    output logic                 hit_o,
    output logic [DataWidth-1:0] data_o
);

    logic [PtrW-1:0] idx;

    // Priority search: a later (younger) valid match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = rptr_i;
        for (int unsigned age = 0; age < Depth; age++) begin
            idx = rptr_i + PtrW'(age);
            if (((PtrW+1)'(age) < count_i) && (raddr_i != 5'd0) &&
                (entries_i[idx].waddr == raddr_i)) begin
                hit_o  = 1'b1;
                data_o = DataWidth'(entries_i[idx].wdata);
            end
        end
    end

endmodule

// File: rtl/ibex_rf_wb_queue.sv
// Register-file write-back queue merging LSU and EX results onto one RF write port.
// Optional forwarding of pending writes is enabled by defining IBEX_RF_WB_FWD_EN.
// DataWidth must not exceed the package entry width (RfWbDataWidth).
module ibex_rf_wb_queue import ibex_pkg::*; #(
    parameter int unsigned DataWidth = RfWbDataWidth,
    parameter int unsigned Depth     = RfWbDepthDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic [4:0]           fwd_raddr_a_i,
    input  logic [4:0]           fwd_raddr_b_i,
    output logic                 fwd_hit_a_o,
    output logic                 fwd_hit_b_o,
    output logic [DataWidth-1:0] fwd_data_a_o,
    output logic [DataWidth-1:0] fwd_data_b_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int unsigned   PtrW       = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt   = (PtrW+1)'(Depth);
    localparam logic [PtrW:0] DepthM1Cnt = (PtrW+1)'(Depth - 1);

    rf_wb_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [PtrW-1:0] ex_slot;
    logic [PtrW:0]   count_q;
    logic [PtrW:0]   push_cnt;
    logic            lsu_push;
    logic            ex_push;
    logic            pop;

    // EX needs two free slots so that a dual push can never overflow the queue.
    assign lsu_ready_o = (count_q < DepthCnt);
    assign ex_ready_o  = (count_q < DepthM1Cnt);

    // Writes to x0 complete the handshake but never occupy a slot.
    assign lsu_push = lsu_valid_i & lsu_ready_o & (lsu_waddr_i != 5'd0);
    assign ex_push  = ex_valid_i & ex_ready_o & (ex_waddr_i != 5'd0);
    assign pop      = (count_q != '0);
    assign push_cnt = (PtrW+1)'(lsu_push) + (PtrW+1)'(ex_push);
    assign ex_slot  = wptr_q + PtrW'(lsu_push);

    // Entry storage is not reset; LSU lands first so it is the older entry.
    always_ff @(posedge clk_i) begin
        if (lsu_push) begin
            mem_q[wptr_q] <= '{waddr: lsu_waddr_i, wdata: RfWbDataWidth'(lsu_wdata_i)};
        end
        if (ex_push) begin
            mem_q[ex_slot] <= '{waddr: ex_waddr_i, wdata: RfWbDataWidth'(ex_wdata_i)};
        end
    end

    // Occupancy and pointers; reset drops every pending write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            count_q <= count_q + push_cnt - (PtrW+1)'(pop);
            wptr_q  <= wptr_q + push_cnt[PtrW-1:0];
            rptr_q  <= rptr_q + PtrW'(pop);
        end
    end

    assign rf_we_o    = pop;
    assign rf_waddr_o = mem_q[rptr_q].waddr;
    assign rf_wdata_o = DataWidth'(mem_q[rptr_q].wdata);
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DepthCnt);

`ifdef IBEX_RF_WB_FWD_EN
    ibex_rf_wb_fwd_lookup #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fwd_a (
        .entries_i (mem_q),
        .rptr_i    (rptr_q),
        .count_i   (count_q),
        .raddr_i   (fwd_raddr_a_i),
        .hit_o     (fwd_hit_a_o),
        .data_o    (fwd_data_a_o)
    );

    ibex_rf_wb_fwd_lookup #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fwd_b (
        .entries_i (mem_q),
        .rptr_i    (rptr_q),
        .count_i   (count_q),
        .raddr_i   (fwd_raddr_b_i),
        .hit_o     (fwd_hit_b_o),
        .data_o    (fwd_data_b_o)
    );
`else
    logic unused_fwd_raddr;

    assign unused_fwd_raddr = ^{fwd_raddr_a_i, fwd_raddr_b_i};
    assign fwd_hit_a_o      = 1'b0;
    assign fwd_hit_b_o      = 1'b0;
    assign fwd_data_a_o     = '0;
    assign fwd_data_b_o     = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_queue.sv
// Scoreboard bench for ibex_rf_wb_queue (Depth 4, 32-bit data).
// Accepted writes are queued by the stimulus side; a negedge monitor checks RF writes and forwarding.
module tb_ibex_rf_wb_queue;

    localparam int DEPTH = 4;
`ifdef IBEX_RF_WB_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } entry_t;

    logic        clk;
    logic        rst_ni;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  fwd_raddr_a_i;
    logic [4:0]  fwd_raddr_b_i;
    logic        fwd_hit_a_o;
    logic        fwd_hit_b_o;
    logic [31:0] fwd_data_a_o;
    logic [31:0] fwd_data_b_o;
    logic        empty_o;
    logic        full_o;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    ibex_rf_wb_queue #(
        .DataWidth (32),
        .Depth     (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_waddr_i   (lsu_waddr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .fwd_raddr_a_i (fwd_raddr_a_i),
        .fwd_raddr_b_i (fwd_raddr_b_i),
        .fwd_hit_a_o   (fwd_hit_a_o),
        .fwd_hit_b_o   (fwd_hit_b_o),
        .fwd_data_a_o  (fwd_data_a_o),
        .fwd_data_b_o  (fwd_data_b_o),
        .empty_o       (empty_o),
        .full_o        (full_o)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached with %0d entries outstanding", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rf_we"},     rf_we_o,     1'b0);
        checkOutput({tag, "_empty"},     empty_o,     1'b1);
        checkOutput({tag, "_full"},      full_o,      1'b0);
        checkOutput({tag, "_lsu_ready"}, lsu_ready_o, 1'b1);
        checkOutput({tag, "_ex_ready"},  ex_ready_o,  1'b1);
        checkOutput({tag, "_hit_a"},     fwd_hit_a_o, 1'b0);
        checkOutput({tag, "_hit_b"},     fwd_hit_b_o, 1'b0);
    endtask

    // Called just after a rising edge; drives one cycle and records what the DUT must accept.
    task automatic applyStimulus(input bit lv, input logic [4:0] la, input logic [31:0] ld,
                                 input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                                 output bit l_acc, output bit e_acc);
        lsu_valid_i = lv;
        lsu_waddr_i = la;
        lsu_wdata_i = ld;
        ex_valid_i  = ev;
        ex_waddr_i  = ea;
        ex_wdata_i  = ed;
        l_acc = lv && (sb.size() < DEPTH);
        e_acc = ev && (sb.size() < DEPTH - 1);
        #1;
        checkOutput("lsu_ready", lsu_ready_o, sb.size() < DEPTH);
        checkOutput("ex_ready",  ex_ready_o,  sb.size() < DEPTH - 1);
        checkOutput("full",      full_o,      sb.size() == DEPTH);
        @(posedge clk);
        if (l_acc && la != 5'd0) sb.push_back('{a: la, d: ld});
        if (e_acc && ea != 5'd0) sb.push_back('{a: ea, d: ed});
        #2;
        lsu_valid_i = 1'b0;
        ex_valid_i  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        bit la, ea;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, ea);
    endtask

    task automatic drainQueue(input string tag);
        bit la, ea;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, ea);
        end
        checkOutput({tag, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: at each falling edge compare forwarding, status and the RF write against the scoreboard.
    initial begin : monitor
        entry_t      e;
        bit          hit_a, hit_b;
        logic [31:0] da, db;
        forever begin
            @(negedge clk);
            hit_a = 1'b0; da = '0;
            hit_b = 1'b0; db = '0;
            foreach (sb[i]) begin
                if (fwd_raddr_a_i != 5'd0 && sb[i].a == fwd_raddr_a_i) begin hit_a = 1'b1; da = sb[i].d; end
                if (fwd_raddr_b_i != 5'd0 && sb[i].a == fwd_raddr_b_i) begin hit_b = 1'b1; db = sb[i].d; end
            end
            if (!FwdEn) begin
                hit_a = 1'b0; da = '0;
                hit_b = 1'b0; db = '0;
            end
            checkOutput("fwd_hit_a",  fwd_hit_a_o,  hit_a);
            checkOutput("fwd_data_a", fwd_data_a_o, da);
            checkOutput("fwd_hit_b",  fwd_hit_b_o,  hit_b);
            checkOutput("fwd_data_b", fwd_data_b_o, db);
            checkOutput("empty",      empty_o,      sb.size() == 0);
            checkOutput("rf_we",      rf_we_o,      sb.size() != 0);
            if (sb.size() != 0 && rf_we_o === 1'b1) begin
                e = sb.pop_front();
                checkOutput("rf_waddr", rf_waddr_o, e.a);
                checkOutput("rf_wdata", rf_wdata_o, e.d);
            end
        end
    end

    // Directed sequence: reset, single, dual, x0, backpressure, reset mid-drain.
    initial begin : stimulus
        bit la, ea;
        int li, ei;
        rst_ni        = 1'b1;
        lsu_valid_i   = 1'b0;
        lsu_waddr_i   = '0;
        lsu_wdata_i   = '0;
        ex_valid_i    = 1'b0;
        ex_waddr_i    = '0;
        ex_wdata_i    = '0;
        fwd_raddr_a_i = '0;
        fwd_raddr_b_i = '0;
        #1 rst_ni = 1'b0;
        #2 checkResetOutputs("por");
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;

        $display("[TB] single write x5=0x11");
        fwd_raddr_a_i = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, la, ea);
        idleCycles(2);

        $display("[TB] dual write x3=0xA (lsu) and x3=0xB (ex)");
        fwd_raddr_a_i = 5'd3;
        fwd_raddr_b_i = 5'd0;
        applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, la, ea);
        drainQueue("dual");
        idleCycles(1);

        $display("[TB] x0 discard");
        fwd_raddr_a_i = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, la, ea);
        idleCycles(2);

        $display("[TB] backpressure with both valids held");
        fwd_raddr_a_i = 5'd20;
        fwd_raddr_b_i = 5'd2;
        li = 0;
        ei = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 5'(1 + li), 32'h100 + 32'(li),
                          1'b1, 5'(20 + ei), 32'h200 + 32'(ei), la, ea);
            if (la) li++;
            if (ea) ei++;
        end
        drainQueue("bp");
        checkOutput("bp_lsu_count", li, 8);
        checkOutput("bp_ex_count",  ei, 2);

        $display("[TB] reset while draining three entries");
        fwd_raddr_a_i = 5'd1;
        fwd_raddr_b_i = 5'd7;
        applyStimulus(1'b1, 5'd1, 32'h31, 1'b1, 5'd2, 32'h32, la, ea);
        applyStimulus(1'b1, 5'd6, 32'h36, 1'b1, 5'd7, 32'h37, la, ea);
        checkOutput("pre_reset_depth", sb.size(), 3);
        rst_ni = 1'b0;
        sb.delete();
        #1 checkResetOutputs("mid");
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;
        idleCycles(3);
        checkResetOutputs("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
